// File: rtl/des_key_scheduler.sv
// DES key schedule sequencer: PC-1 on load, 16 rounds of C/D rotation,
// PC-2 round key per round presented over a valid/ready handshake.
// Encrypt order K1..K16 (left rotations), decrypt order K16..K1 (right rotations).
// DES bit 1 is the MSB of every vector (key_in[63], cd_q[55], round_key[47]).
module des_key_scheduler #(
    parameter int USE_PC1 = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [63:0] key_in,
    input  logic        abort,
    output logic        busy,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [47:0] round_key,
    output logic [3:0]  round_num,
    output logic        done
);

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    localparam int unsigned PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    state_t      state_q;
    logic        mode_q;
    logic [55:0] cd_q;
    logic [55:0] c0d0;
    logic        unused_key_bits;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            r[55 - i] = k[64 - PC1_TBL[i]];
        end
        return r;
    endfunction

    // Shift amount of round r (1..16): returns 1 when the round rotates by two.
    function automatic logic shift_two(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // C and D rotate independently
    function automatic logic [55:0] rotl56(input logic [55:0] x, input logic two);
        return {rotl28(x[55:28], two), rotl28(x[27:0], two)};
    endfunction

    function automatic logic [55:0] rotr56(input logic [55:0] x, input logic two);
        return {rotr28(x[55:28], two), rotr28(x[27:0], two)};
    endfunction

    // Parity bits (and the whole low byte when PC-1 is bypassed) carry no key material.
    assign unused_key_bits = ^key_in;

    assign c0d0 = (USE_PC1 != 0) ? pc1(key_in) : key_in[63:8];

    // Round key is PC-2 of the C/D register, purely from registered state
    always_comb begin
        round_key = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            round_key[47 - i] = cd_q[56 - PC2_TBL[i]];
        end
    end

    // Schedule FSM: load on start, step C/D on each accepted key, abort returns to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            cd_q      <= '0;
            round_num <= '0;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state_q   <= IDLE;
                round_num <= '0;
                busy      <= 1'b0;
                rk_valid  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            mode_q    <= mode;
                            // Decrypt starts from C16D16, which equals C0D0 (28 total shifts)
                            cd_q      <= mode ? c0d0 : rotl56(c0d0, 1'b0);
                            round_num <= '0;
                            state_q   <= RUN;
                            busy      <= 1'b1;
                            rk_valid  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (rk_ready) begin
                            if (round_num == 4'd15) begin
                                state_q   <= IDLE;
                                round_num <= '0;
                                busy      <= 1'b0;
                                rk_valid  <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                round_num <= round_num + 4'd1;
                                cd_q      <= mode_q
                                    ? rotr56(cd_q, shift_two(5'd16 - {1'b0, round_num}))
                                    : rotl56(cd_q, shift_two({1'b0, round_num} + 5'd2));
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Directed bench for des_key_scheduler using the classic DES example key.
module tb_des_key_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start0;
    logic        mode;
    logic [63:0] key_in, key0;
    logic        abort;
    logic        rk_ready;
    logic        busy, rk_valid, done;
    logic [47:0] round_key;
    logic [3:0]  round_num;
    logic        busy0, rk_valid0, done0;
    logic [47:0] round_key0;
    logic [3:0]  round_num0;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [55:0] CD0  = 56'hF0CCAAF556678F;

    logic [47:0] ek [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    always #5 clk = ~clk;

    des_key_scheduler #(.USE_PC1(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key_in(key_in),
        .abort(abort), .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .round_key(round_key), .round_num(round_num), .done(done)
    );

    des_key_scheduler #(.USE_PC1(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode), .key_in(key0),
        .abort(abort), .busy(busy0), .rk_valid(rk_valid0), .rk_ready(rk_ready),
        .round_key(round_key0), .round_num(round_num0), .done(done0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] pat;
        int idx;
        int cyc;

        rst_n = 1'b0; start = 1'b0; start0 = 1'b0; mode = 1'b0; abort = 1'b0;
        rk_ready = 1'b0; key_in = '0; key0 = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(rk_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rn", 64'(round_num), 64'd0);
        check("rst_rk", 64'(round_key), 64'd0);
        check("rst_valid0", 64'(rk_valid0), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_valid", 64'(rk_valid), 64'd0);

        // Scenario 1: encrypt, always ready
        mode = 1'b0; key_in = KEY; rk_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("s1_busy", 64'(busy), 64'd1);
        check("s1_valid", 64'(rk_valid), 64'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("s1_rn%0d", i), 64'(round_num), 64'(i));
            check($sformatf("s1_rk%0d", i), 64'(round_key), 64'(ek[i]));
            check($sformatf("s1_done_low%0d", i), 64'(done), 64'd0);
            tick();
        end
        check("s1_done", 64'(done), 64'd1);
        check("s1_end_valid", 64'(rk_valid), 64'd0);
        check("s1_end_busy", 64'(busy), 64'd0);
        check("s1_end_rn", 64'(round_num), 64'd0);

        // Scenario 2: decrypt, started back-to-back in the done cycle
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("s2_done_pulse", 64'(done), 64'd0);
        check("s2_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("s2_rn%0d", i), 64'(round_num), 64'(i));
            check($sformatf("s2_rk%0d", i), 64'(round_key), 64'(ek[15 - i]));
            tick();
        end
        check("s2_done", 64'(done), 64'd1);
        tick();
        check("s2_done_clr", 64'(done), 64'd0);

        // Scenario 3: encrypt with back-pressure
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        pat = 16'b1011_0010_1110_0101;
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 100) begin
            rk_ready = pat[cyc % 16];
            check($sformatf("s3_rn_c%0d", cyc), 64'(round_num), 64'(idx));
            check($sformatf("s3_rk_c%0d", cyc), 64'(round_key), 64'(ek[idx]));
            check($sformatf("s3_valid_c%0d", cyc), 64'(rk_valid), 64'd1);
            tick();
            if (rk_ready) idx++;
            cyc++;
        end
        check("s3_accepts", 64'(idx), 64'd16);
        check("s3_done", 64'(done), 64'd1);
        rk_ready = 1'b1;

        // Scenario 4: start ignored while busy, then abort
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("s4_rn5", 64'(round_num), 64'd5);
        check("s4_rk5", 64'(round_key), 64'(ek[5]));
        start = 1'b1; key_in = 64'h0123456789ABCDEF; mode = 1'b1;
        tick();
        start = 1'b0; key_in = KEY; mode = 1'b0;
        check("s4_rn6", 64'(round_num), 64'd6);
        check("s4_rk6", 64'(round_key), 64'(ek[6]));
        tick();
        check("s4_rk7", 64'(round_key), 64'(ek[7]));
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("s4_abort_valid", 64'(rk_valid), 64'd0);
        check("s4_abort_busy", 64'(busy), 64'd0);
        check("s4_abort_done", 64'(done), 64'd0);
        check("s4_abort_rn", 64'(round_num), 64'd0);
        tick();
        check("s4_abort_done2", 64'(done), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s4_restart_rk", 64'(round_key), 64'(ek[0]));
        check("s4_restart_rn", 64'(round_num), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("s4_abort2_valid", 64'(rk_valid), 64'd0);

        // Scenario 5: asynchronous reset mid-schedule
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("s5_rn10", 64'(round_num), 64'd10);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_valid", 64'(rk_valid), 64'd0);
        check("s5_rst_busy", 64'(busy), 64'd0);
        check("s5_rst_rn", 64'(round_num), 64'd0);
        check("s5_rst_rk", 64'(round_key), 64'd0);
        check("s5_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("s5_post_valid", 64'(rk_valid), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("s5_rk%0d", i), 64'(round_key), 64'(ek[i]));
            tick();
        end
        check("s5_done", 64'(done), 64'd1);

        // Scenario 6: PC-1 bypassed, C0D0 supplied directly
        mode = 1'b0; key0 = {CD0, 8'hA5}; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("s6_rn%0d", i), 64'(round_num0), 64'(i));
            check($sformatf("s6_rk%0d", i), 64'(round_key0), 64'(ek[i]));
            tick();
        end
        check("s6_done", 64'(done0), 64'd1);
        check("s6_idle_valid", 64'(rk_valid0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
